// File: rtl/radix_r_mul_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : radix_r_mul_seq_pkg
// Function : Shared definitions for the radix-4 sequential multiplier:
//            default operand width, default fraction bits and FSM encoding.
// Revision : 1.0 - initial release
// ============================================================================
package radix_r_mul_seq_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_SCALE = 17;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ITER   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mux_4_to_1_param.sv
`default_nettype none
// ============================================================================
// Module   : mux_4_to_1_param
// Function : Parameterised-width 4:1 multiplexer, 2-bit select. Used to pick
//            the radix-4 partial product {0, |A|, 2|A|, 3|A|}.
// Revision : 1.0 - initial release
// ============================================================================
module mux_4_to_1_param
    import radix_r_mul_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH + 2
)(
    input  logic [WIDTH-1:0] i_d0,
    input  logic [WIDTH-1:0] i_d1,
    input  logic [WIDTH-1:0] i_d2,
    input  logic [WIDTH-1:0] i_d3,
    input  logic [1:0]       i_sel,
    output logic [WIDTH-1:0] o_y
);

    // Pure selection: route the input chosen by the current digit
    always_comb begin
        o_y = i_d0;
        case (i_sel)
            2'd0:    o_y = i_d0;
            2'd1:    o_y = i_d1;
            2'd2:    o_y = i_d2;
            2'd3:    o_y = i_d3;
            default: o_y = i_d0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/radix_r_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : radix_r_mul_seq
// Function : Sequential radix-4 sign/magnitude multiplier. One 2-bit digit of
//            |B| is consumed per cycle; the optional fixed-point right shift
//            and sign restoration happen in a single FINISH cycle.
// Revision : 1.0 - initial release
// ============================================================================
module radix_r_mul_seq
    import radix_r_mul_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SCALE = DEFAULT_SCALE
)(
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 iInputReady,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic                 iSigned,
    input  logic                 iUnscaled,
    output logic [2*WIDTH-1:0]   R,
    output logic                 OutputReady,
    output logic                 oBusy
);

    localparam int PROD_W = 2 * WIDTH;
    localparam int SEL_W  = WIDTH + 2;
    localparam int CNT_W  = $clog2(WIDTH / 2);
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(WIDTH / 2 - 1);

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    a_q, a_d;
    logic [SEL_W-1:0]    a3_q, a3_d;
    logic [WIDTH-1:0]    b_q, b_d;
    logic [PROD_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                sign_q, sign_d;
    logic                unscaled_q, unscaled_d;
    logic [PROD_W-1:0]   r_q, r_d;
    logic                ready_q, ready_d;

    logic [WIDTH-1:0]    w_a_mag;
    logic [WIDTH-1:0]    w_b_mag;
    logic [1:0]          w_digit;
    logic [SEL_W-1:0]    w_sel;
    logic [PROD_W-1:0]   w_addend;
    logic [PROD_W-1:0]   w_prod;

    // Operand magnitudes; negating -2^(W-1) wraps back to 2^(W-1) unsigned
    always_comb begin
        w_a_mag = (iSigned && A[WIDTH-1]) ? (~A + 1'b1) : A;
        w_b_mag = (iSigned && B[WIDTH-1]) ? (~B + 1'b1) : B;
    end

    assign w_digit = b_q[{cnt_q, 1'b0} +: 2];

    mux_4_to_1_param #(
        .WIDTH (SEL_W)
    ) u_digit_mux (
        .i_d0  ({SEL_W{1'b0}}),
        .i_d1  ({2'b00, a_q}),
        .i_d2  ({1'b0, a_q, 1'b0}),
        .i_d3  (a3_q),
        .i_sel (w_digit),
        .o_y   (w_sel)
    );

    // Partial product aligned to the weight of the current digit
    always_comb begin
        w_addend = {{(PROD_W - SEL_W){1'b0}}, w_sel} << {cnt_q, 1'b0};
        w_prod   = unscaled_q ? acc_q : (acc_q >> SCALE);
    end

    // Next-state and datapath updates; everything holds unless the state acts
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        a3_d       = a3_q;
        b_d        = b_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        sign_d     = sign_q;
        unscaled_d = unscaled_q;
        r_d        = r_q;
        ready_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (iInputReady) begin
                    a_d        = w_a_mag;
                    a3_d       = {2'b00, w_a_mag} + {1'b0, w_a_mag, 1'b0};
                    b_d        = w_b_mag;
                    sign_d     = (A[WIDTH-1] ^ B[WIDTH-1]) & iSigned;
                    unscaled_d = iUnscaled;
                    acc_d      = '0;
                    cnt_d      = '0;
                    state_d    = ST_ITER;
                end
            end
            ST_ITER: begin
                acc_d = acc_q + w_addend;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_DIGIT) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                r_d     = sign_q ? (~w_prod + 1'b1) : w_prod;
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with asynchronous clear
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            a_q        <= '0;
            a3_q       <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            sign_q     <= 1'b0;
            unscaled_q <= 1'b0;
            r_q        <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            a3_q       <= a3_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            sign_q     <= sign_d;
            unscaled_q <= unscaled_d;
            r_q        <= r_d;
            ready_q    <= ready_d;
        end
    end

    assign R           = r_q;
    assign OutputReady = ready_q;
    assign oBusy       = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/radix_r_mul_seq.md
RADIX_R_MUL_SEQ -- requirements
Module: radix_r_mul_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand width; SHALL be even and >= 4.
REQ-002 Parameter SCALE, default 17, fixed-point fraction bits; SHALL satisfy 0 <= SCALE < 2*WIDTH.
REQ-003 Clock  input  1  single clock; all state changes on its rising edge.
REQ-004 Reset  input  1  reset, asynchronous and active-high.
REQ-005 iInputReady  input  1  request; A, B and mode inputs are valid this cycle.
REQ-006 A  input  WIDTH  multiplicand.
REQ-007 B  input  WIDTH  multiplier.
REQ-008 iSigned  input  1  1 = two's-complement operands; 0 = unsigned.
REQ-009 iUnscaled  input  1  1 = full product; 0 = product shifted right by SCALE.
REQ-010 R  output  2*WIDTH  registered result, held until the next result.
REQ-011 OutputReady  output  1  one-cycle pulse: R is valid.
REQ-012 oBusy  output  1  high while an operation is in progress; iInputReady is ignored while high.

Function
REQ-013 FSM states SHALL be IDLE, ITER and FINISH; oBusy SHALL be 1 exactly in ITER and FINISH.
REQ-014 IDLE with iInputReady=1 at an edge: latch |A|, |B|, sign = (A[W-1]^B[W-1]) & iSigned, and iUnscaled; clear accumulator and digit counter; go to ITER.
REQ-015 Magnitude SHALL be the two's-complement negation when iSigned=1 and the MSB=1, else the raw value; -2^(W-1) SHALL yield 2^(W-1) as a W-bit unsigned value, with no overflow.
REQ-016 ITER: each cycle, select one of {0, |A|, 2|A|, 3|A|} with the current 2-bit digit of |B| (LSB digit first); add it, shifted by 2*digit index, into a 2*WIDTH accumulator; increment the counter.
REQ-017 3|A| SHALL be precomputed once at accept time and held in a (WIDTH+2)-bit register.
REQ-018 After WIDTH/2 ITER cycles, go to FINISH; FINISH lasts exactly one cycle, then returns to IDLE.
REQ-019 FINISH: P = accumulator, or accumulator >> SCALE (logical) when iUnscaled=0; R = sign ? -P : P (mod 2^(2W)); pulse OutputReady.
REQ-020 Scaled signed results SHALL therefore truncate toward zero.
REQ-021 Latency: OutputReady SHALL be high in the cycle after the (WIDTH/2 + 1)th rising edge following the accepting edge (17 edges for WIDTH=32).
REQ-022 iInputReady during ITER/FINISH SHALL be dropped, with no queuing and no effect on the running operation.
REQ-023 iInputReady in the cycle OutputReady is high SHALL be accepted (state is IDLE); throughput is one result per WIDTH/2+2 cycles.
REQ-024 A, B and the mode inputs SHALL be sampled only on the accepting edge; changes afterwards SHALL have no effect.
REQ-025 R SHALL change only on the FINISH edge.

Reset
REQ-026 Reset asserted SHALL immediately force state IDLE, counter 0, accumulator 0, R 0, OutputReady 0 and oBusy 0, independent of Clock.
REQ-027 Reset mid-operation SHALL abort the operation with no OutputReady pulse; the first edge after deassertion SHALL accept a new request.

Structure
REQ-028 Default WIDTH and SCALE SHALL come from the shared definitions include, with no literals in the module.
REQ-029 One sub-module, mux_4_to_1_param (WIDTH+2 bits, 2-bit select), SHALL perform the digit selection.
REQ-030 The accumulator, |A|, 3|A|, |B|, the counter and the flags SHALL be the only storage; no multiplier primitives SHALL be inferred.

Verification (WIDTH=32, SCALE=17)
REQ-031 iSigned=0, iUnscaled=1, A=3, B=5 -> R=15; OutputReady exactly 17 edges after accept; oBusy high for 17 cycles.
REQ-032 iSigned=1, iUnscaled=1, A=0xFFFFFFFF, B=2 -> R=0xFFFFFFFF_FFFFFFFE; A=B=0x80000000 -> R=0x40000000_00000000.
REQ-033 iSigned=1, iUnscaled=0: A=0x40000, B=0x60000 -> R=0xC0000; A=0xFFFC0000, B=0x60000 -> R=0xFFFFFFFF_FFF40000.
REQ-034 iSigned=0, iUnscaled=1, A=B=0xFFFFFFFF -> R=0xFFFFFFFE_00000001.
REQ-035 Extra iInputReady pulses at edges 3 and 10 after an accept -> ignored, R unchanged; new request in the OutputReady cycle -> accepted, next result 17 edges later.
REQ-036 Reset asserted at edge 8 of an operation -> outputs 0 immediately, no OutputReady; request after release -> correct result.
